// File: rtl/lpc_io_initiator.sv
// LPC host-side I/O initiator.
// Turns a single-entry I/O read/write request into LPC START/CYCTYPE/ADDR/DATA/TAR/SYNC
// sequencing on LAD[3:0] and LFRAME#, then reports completion, status and read data.
//
// Ports:
//   LpcClock   33 MHz LPC clock, rising edge
//   PciReset   synchronous active-high reset
//   Req        request strobe, accepted while Busy=0
//   ReqWr      1 = I/O write, 0 = I/O read (sampled with Req)
//   ReqAddr    16-bit I/O address (sampled with Req)
//   ReqData    write data (sampled with Req)
//   Busy       transaction in progress
//   Done       one-clock completion pulse
//   Error      valid with Done: error SYNC, timeout or abort
//   RdData     read data, valid with Done and held afterwards
//   LpcFrame   LFRAME#, active low
//   LpcBusOut  LAD drive value
//   LpcBusOe   LAD output enable
//   LpcBusIn   LAD sampled value
module lpc_io_initiator #(
  parameter int unsigned SYNC_TIMEOUT  = 8,
  parameter int unsigned LONG_WAIT_MAX = 255,
  parameter int unsigned ABORT_CYCLES  = 4
) (
  input  logic        LpcClock,
  input  logic        PciReset,
  input  logic        Req,
  input  logic        ReqWr,
  input  logic [15:0] ReqAddr,
  input  logic [7:0]  ReqData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [7:0]  RdData,
  output logic        LpcFrame,
  output logic [3:0]  LpcBusOut,
  output logic        LpcBusOe,
  input  logic [3:0]  LpcBusIn
);

  localparam int unsigned ShortW = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned LongW  = $clog2(LONG_WAIT_MAX + 1);
  localparam int unsigned AbortW = $clog2(ABORT_CYCLES);

  localparam logic [ShortW-1:0] ShortLimit = ShortW'(SYNC_TIMEOUT);
  localparam logic [LongW-1:0]  LongLimit  = LongW'(LONG_WAIT_MAX);
  localparam logic [AbortW-1:0] AbortLast  = AbortW'(ABORT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StCyc, StAddr, StData, StHTar0, StHTar1,
    StSync, StRData, StPTar, StAbort, StAbortEnd, StDone
  } state_e;

  state_e            state;
  logic              reqWr;
  logic [15:0]       addrSh;   // shifts left one nibble per ADDR clock
  logic [7:0]        reqData;
  logic [1:0]        nibCnt;
  logic              errFlag;
  logic [3:0]        rdLow;
  logic [ShortW-1:0] shortCnt;
  logic [LongW-1:0]  longCnt;
  logic [AbortW-1:0] abortCnt;
  logic [ShortW-1:0] shortInc;
  logic [LongW-1:0]  longInc;

  // Saturating increments of the SYNC wait counters
  always_comb begin
    shortInc = (shortCnt == ShortLimit) ? shortCnt : shortCnt + 1'b1;
    longInc  = (longCnt == LongLimit) ? longCnt : longCnt + 1'b1;
  end

  // Outputs are registered alongside the state: each branch loads the values for the
  // state being entered.
  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state     <= StIdle;
      reqWr     <= 1'b0;
      addrSh    <= '0;
      reqData   <= '0;
      nibCnt    <= '0;
      errFlag   <= 1'b0;
      rdLow     <= '0;
      shortCnt  <= '0;
      longCnt   <= '0;
      abortCnt  <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      RdData    <= '0;
      LpcFrame  <= 1'b1;
      LpcBusOut <= 4'hF;
      LpcBusOe  <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      unique case (state)
        // Busy is already low in DONE, so a request there is taken like in IDLE
        StIdle, StDone: begin
          state <= StIdle;
          if (Req) begin
            reqWr     <= ReqWr;
            addrSh    <= ReqAddr;
            reqData   <= ReqData;
            errFlag   <= 1'b0;
            Busy      <= 1'b1;
            LpcFrame  <= 1'b0;
            LpcBusOut <= 4'h0;
            LpcBusOe  <= 1'b1;
            state     <= StStart;
          end
        end
        StStart: begin
          LpcFrame  <= 1'b1;
          LpcBusOut <= reqWr ? 4'h2 : 4'h0;
          state     <= StCyc;
        end
        StCyc: begin
          LpcBusOut <= addrSh[15:12];
          addrSh    <= {addrSh[11:0], 4'h0};
          nibCnt    <= 2'd0;
          state     <= StAddr;
        end
        StAddr: begin
          if (nibCnt != 2'd3) begin
            LpcBusOut <= addrSh[15:12];
            addrSh    <= {addrSh[11:0], 4'h0};
            nibCnt    <= nibCnt + 2'd1;
          end else if (reqWr) begin
            LpcBusOut <= reqData[3:0];
            nibCnt    <= 2'd0;
            state     <= StData;
          end else begin
            LpcBusOut <= 4'hF;
            state     <= StHTar0;
          end
        end
        StData: begin
          if (nibCnt == 2'd0) begin
            LpcBusOut <= reqData[7:4];
            nibCnt    <= 2'd1;
          end else begin
            LpcBusOut <= 4'hF;
            state     <= StHTar0;
          end
        end
        StHTar0: begin
          LpcBusOe <= 1'b0;
          state    <= StHTar1;
        end
        StHTar1: begin
          shortCnt <= '0;
          longCnt  <= '0;
          state    <= StSync;
        end
        StSync: begin
          if (LpcBusIn == 4'h0 || LpcBusIn == 4'hA) begin
            if (LpcBusIn == 4'hA) errFlag <= 1'b1;
            shortCnt <= '0;
            longCnt  <= '0;
            nibCnt   <= 2'd0;
            state    <= reqWr ? StPTar : StRData;
          end else begin
            if (LpcBusIn == 4'h6) begin
              shortCnt <= '0;
              longCnt  <= longInc;
            end else begin
              shortCnt <= shortInc;
            end
            if ((LpcBusIn == 4'h6 && longInc == LongLimit) ||
                (LpcBusIn != 4'h6 && shortInc == ShortLimit)) begin
              shortCnt  <= '0;
              longCnt   <= '0;
              abortCnt  <= '0;
              LpcFrame  <= 1'b0;
              LpcBusOut <= 4'hF;
              LpcBusOe  <= 1'b1;
              state     <= StAbort;
            end
          end
        end
        StRData: begin
          if (nibCnt == 2'd0) begin
            rdLow  <= LpcBusIn;
            nibCnt <= 2'd1;
          end else begin
            RdData <= {LpcBusIn, rdLow};
            nibCnt <= 2'd0;
            state  <= StPTar;
          end
        end
        StPTar: begin
          if (nibCnt == 2'd0) begin
            nibCnt <= 2'd1;
          end else begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Error <= errFlag;
            state <= StDone;
          end
        end
        StAbort: begin
          if (abortCnt == AbortLast) begin
            LpcFrame <= 1'b1;
            LpcBusOe <= 1'b0;
            state    <= StAbortEnd;
          end else begin
            abortCnt <= abortCnt + 1'b1;
          end
        end
        StAbortEnd: begin
          Busy  <= 1'b0;
          Done  <= 1'b1;
          Error <= 1'b1;
          state <= StDone;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/lpc_io_initiator.md
Name: lpc_io_initiator

Overview:
- LPC host-side initiator for the board LPC link; the peripheral-side decoder/register block is the other end of this link.
- Converts a single-entry request (I/O read or I/O write, 16-bit address, 8-bit data) into LPC START/CYCTYPE/ADDR/DATA/TAR/SYNC sequencing on LAD[3:0] and LFRAME#.
- Returns read data and completion status.
- Used by the bench model and by the BMC-side bridge to access CPLD registers.

Parameters:
- SYNC_TIMEOUT, 8, maximum consecutive SYNC cycles carrying 1111, a short wait (0101) or an invalid code before abort.
- LONG_WAIT_MAX, 255, maximum consecutive long-wait (0110) SYNC cycles before abort.
- ABORT_CYCLES, 4, number of clocks LpcFrame is held low during abort (minimum 4).

Ports:
- LpcClock  in  1  33 MHz LPC clock; all logic is on the rising edge.
- PciReset  in  1  reset; synchronous, active-high.
- Req  in  1  request strobe; accepted only when Busy=0.
- ReqWr  in  1  1 = I/O write, 0 = I/O read; sampled with Req.
- ReqAddr  in  16  I/O address; sampled with Req.
- ReqData  in  8  write data; sampled with Req.
- Busy  out  1  transaction in progress.
- Done  out  1  one-clock pulse on completion.
- Error  out  1  valid with Done: 1 = error SYNC (1010), timeout or abort.
- RdData  out  8  read data; valid with Done, held until the next accepted Req.
- LpcFrame  out  1  LFRAME#, active low.
- LpcBusOut  out  4  LAD drive value.
- LpcBusOe  out  1  LAD output enable.
- LpcBusIn  in  4  LAD sampled value.

Behaviour:
- Reset (PciReset=1 at clock edge): state IDLE; LpcFrame=1; LpcBusOut=4'hF; LpcBusOe=0; Busy=0; Done=0; Error=0; RdData=0. Reset mid-transaction returns to IDLE on the next edge with no abort sequence.
- IDLE: Req=1 latches ReqWr, ReqAddr and ReqData, sets Busy=1, and moves to START on the next clock. Req while Busy=1 is ignored.
- Clock numbering: c0 = START.
  - START (c0): LpcFrame=0, LAD=0000, Oe=1.
  - CYC (c1): LpcFrame=1, LAD=0010 (write) or 0000 (read).
  - ADDR (c2..c5): nibbles [15:12], [11:8], [7:4], [3:0].
  - Write path: DATA (c6..c7), low nibble first; H_TAR0 drives 1111 with Oe=1; H_TAR1 has Oe=0.
  - Read path: H_TAR0 at c6, H_TAR1 at c7.
- SYNC (Oe=0), sampling LpcBusIn each clock:
  - 0000 (ready): read → RDATA; write → P_TAR.
  - 1010 (error): set error flag; read → RDATA; write → P_TAR.
  - 0110 (long wait): increment long counter, clear short counter.
  - 0101, 1111 or any other code: increment short counter.
  - Short counter == SYNC_TIMEOUT or long counter == LONG_WAIT_MAX → ABORT.
- RDATA: two clocks; low nibble captured first, then high nibble into RdData. Error-SYNC reads still capture data.
- P_TAR: two clocks, Oe=0; LAD is ignored.
- DONE: one clock. Done=1, Error=flag, Busy=0 in the same cycle. Next state IDLE.
- Earliest latency: write Done at c13, read Done at c13, both with an immediate ready SYNC (c10 for writes, c8 for reads). Busy is high c0..c12.
- ABORT: LpcFrame=0, LAD=1111, Oe=1 for ABORT_CYCLES clocks; then one clock with LpcFrame=1, Oe=0; then DONE with Error=1. RdData is left unchanged on abort.
- Counters saturate. Both counters clear on leaving SYNC.
- LpcBusOe is never 1 during SYNC, RDATA or P_TAR.

Test Plan:
- Write 0x0084←0xA5, ready SYNC at first sample → LAD sequence 0,2,0,0,8,4,5,A,F,(Z), Done at c13, Error=0.
- Read 0x0009, bus returns 0000 then nibbles 3,C → RdData=0xC3, Done=1 with Error=0 at c13.
- Read with 3× 0110 before 0000 → Done delayed by 3 clocks, Error=0, RdData correct.
- Write with LAD held 1111 (no peripheral) → after 8 SYNC clocks, LpcFrame low 4 clocks with LAD=1111, then Done with Error=1.
- Read with SYNC=1010, data 0x5A → Done, Error=1, RdData=0x5A.
- PciReset pulsed during ADDR, plus Req asserted while Busy=1 → all outputs at reset values next clock; the second Req produces no transaction.
